// File: rtl/eth_tx_mac_gen2.sv
// Ethernet TX MAC: preamble/SFD, min-frame padding, CRC-32 FCS, IFG.
// Byte-per-cycle (gigabit) or byte-per-two-cycles (MII) output pacing.
module eth_tx_mac_gen2 #(
   parameter bit          PREAMBLE_EN     = 1'b1,
   parameter bit          PAD_EN          = 1'b1,
   parameter int unsigned MIN_FRAME_BYTES = 60,
   parameter bit          CRC_EN          = 1'b1,
   parameter int unsigned IFG_BYTES       = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] s_tx_axis_tdata,
   input  logic       s_tx_axis_tvalid,
   input  logic       s_tx_axis_tlast,
   input  logic       s_tx_axis_tuser,
   output logic       s_tx_axis_trdy,
   input  logic       rgmii_mac_tx_rdy,
   output logic [7:0] rgmii_mac_tx_data,
   output logic       rgmii_mac_tx_dv,
   output logic       rgmii_mac_tx_er,
   input  logic       mii_select,
   output logic       frame_done,
   output logic       underrun
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PRE   = 3'd1;
   localparam logic [2:0] S_PAY   = 3'd2;
   localparam logic [2:0] S_PAD   = 3'd3;
   localparam logic [2:0] S_FCS   = 3'd4;
   localparam logic [2:0] S_DRAIN = 3'd5;
   localparam logic [2:0] S_IFG   = 3'd6;

   localparam logic [2:0]  S_END    = CRC_EN ? S_FCS : S_IFG;
   localparam logic [16:0] MIN_LEN  = 17'(MIN_FRAME_BYTES);
   localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

   logic [2:0]  state;
   logic        mode_mii;
   logic        phase;
   logic [2:0]  pre_cnt;
   logic [15:0] byte_cnt;
   logic [1:0]  fcs_idx;
   logic [7:0]  ifg_cnt;
   logic [31:0] crc;

   logic        adv;
   logic [7:0]  crc_in;
   logic [31:0] crc_nxt;
   logic [16:0] cnt_inc;
   logic [15:0] cnt_sat;
   logic [31:0] fcs;
   logic [7:0]  fcs_byte;

   function automatic logic [31:0] crc_byte(
      input logic [31:0] c,
      input logic [7:0]  d
   );
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   // IDLE ignores phase so a frame can start on any ready cycle.
   assign adv = rgmii_mac_tx_rdy &&
                (state == S_IDLE || !mode_mii || phase);

   always_comb begin
      s_tx_axis_trdy = 1'b0;
      if (state == S_PAY)   s_tx_axis_trdy = adv;
      if (state == S_DRAIN) s_tx_axis_trdy = rgmii_mac_tx_rdy;
   end

   assign crc_in   = (state == S_PAY) ? s_tx_axis_tdata : 8'h00;
   assign crc_nxt  = crc_byte(crc, crc_in);
   assign cnt_inc  = {1'b0, byte_cnt} + 17'd1;
   assign cnt_sat  = (&byte_cnt) ? byte_cnt : cnt_inc[15:0];
   assign fcs      = ~crc;
   assign fcs_byte = 8'(fcs >> {fcs_idx, 3'b000});

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= S_IDLE;
         mode_mii          <= 1'b0;
         phase             <= 1'b0;
         pre_cnt           <= '0;
         byte_cnt          <= '0;
         fcs_idx           <= '0;
         ifg_cnt           <= '0;
         crc               <= '1;
         rgmii_mac_tx_data <= '0;
         rgmii_mac_tx_dv   <= 1'b0;
         rgmii_mac_tx_er   <= 1'b0;
         frame_done        <= 1'b0;
         underrun          <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         underrun   <= 1'b0;
         if (state == S_IDLE)
            phase <= 1'b0;
         else if (rgmii_mac_tx_rdy && mode_mii)
            phase <= ~phase;
         if (adv) begin
            unique case (state)
               S_IDLE: begin
                  if (s_tx_axis_tvalid) begin
                     mode_mii <= mii_select;
                     if (PREAMBLE_EN) begin
                        rgmii_mac_tx_data <= 8'h55;
                        rgmii_mac_tx_dv   <= 1'b1;
                        rgmii_mac_tx_er   <= 1'b0;
                        pre_cnt           <= 3'd1;
                        state             <= S_PRE;
                     end else begin
                        state <= S_PAY;
                     end
                  end
               end
               S_PRE: begin
                  rgmii_mac_tx_data <= (pre_cnt == 3'd7) ? 8'hD5 : 8'h55;
                  rgmii_mac_tx_dv   <= 1'b1;
                  rgmii_mac_tx_er   <= 1'b0;
                  pre_cnt           <= pre_cnt + 3'd1;
                  if (pre_cnt == 3'd7) state <= S_PAY;
               end
               S_PAY: begin
                  if (s_tx_axis_tvalid) begin
                     rgmii_mac_tx_data <= s_tx_axis_tdata;
                     rgmii_mac_tx_dv   <= 1'b1;
                     rgmii_mac_tx_er   <= s_tx_axis_tuser;
                     crc               <= crc_nxt;
                     byte_cnt          <= cnt_sat;
                     fcs_idx           <= '0;
                     ifg_cnt           <= '0;
                     if (s_tx_axis_tlast) begin
                        if (PAD_EN && cnt_inc < MIN_LEN) begin
                           state <= S_PAD;
                        end else begin
                           state      <= S_END;
                           frame_done <= !CRC_EN;
                        end
                     end
                  end else begin
                     rgmii_mac_tx_data <= 8'h00;
                     rgmii_mac_tx_dv   <= 1'b1;
                     rgmii_mac_tx_er   <= 1'b1;
                     underrun          <= 1'b1;
                     state             <= S_DRAIN;
                  end
               end
               S_PAD: begin
                  rgmii_mac_tx_data <= 8'h00;
                  rgmii_mac_tx_dv   <= 1'b1;
                  rgmii_mac_tx_er   <= 1'b0;
                  crc               <= crc_nxt;
                  byte_cnt          <= cnt_sat;
                  if (cnt_inc >= MIN_LEN) begin
                     state      <= S_END;
                     frame_done <= !CRC_EN;
                  end
               end
               S_FCS: begin
                  rgmii_mac_tx_data <= fcs_byte;
                  rgmii_mac_tx_dv   <= 1'b1;
                  rgmii_mac_tx_er   <= 1'b0;
                  fcs_idx           <= fcs_idx + 2'd1;
                  if (fcs_idx == 2'd3) begin
                     frame_done <= 1'b1;
                     state      <= S_IFG;
                  end
               end
               S_DRAIN: begin
                  rgmii_mac_tx_data <= 8'h00;
                  rgmii_mac_tx_dv   <= 1'b0;
                  rgmii_mac_tx_er   <= 1'b0;
               end
               S_IFG: begin
                  rgmii_mac_tx_data <= 8'h00;
                  rgmii_mac_tx_dv   <= 1'b0;
                  rgmii_mac_tx_er   <= 1'b0;
                  if (ifg_cnt == IFG_LAST) begin
                     ifg_cnt  <= '0;
                     crc      <= '1;
                     byte_cnt <= '0;
                     state    <= S_IDLE;
                  end else begin
                     ifg_cnt <= ifg_cnt + 8'd1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
         // Draining runs every ready cycle, independent of MII pacing.
         if (state == S_DRAIN && s_tx_axis_trdy &&
             s_tx_axis_tvalid && s_tx_axis_tlast) begin
            ifg_cnt <= '0;
            state   <= S_IFG;
         end
      end
   end

endmodule

// File: tb/tb_eth_tx_mac_gen2.sv
// Bench for eth_tx_mac_gen2: byte-stream model plus directed
// checks on timing, padding, FCS, MII pacing, underrun and reset.
module tb_eth_tx_mac_gen2;

   logic       clk;
   logic       reset;
   logic [7:0] tdata;
   logic       tvalid, tlast, tuser, trdy;
   logic       tx_rdy, mii_sel;
   logic [7:0] txd;
   logic       dv, er, fdone, urun;

   logic [7:0] b_tdata;
   logic       b_tvalid, b_tlast, b_tuser, b_trdy;
   logic       b_rdy, b_mii;
   logic [7:0] b_txd;
   logic       b_dv, b_er, b_fdone, b_urun;

   eth_tx_mac_gen2 dut (
      .clk               (clk),
      .reset             (reset),
      .s_tx_axis_tdata   (tdata),
      .s_tx_axis_tvalid  (tvalid),
      .s_tx_axis_tlast   (tlast),
      .s_tx_axis_tuser   (tuser),
      .s_tx_axis_trdy    (trdy),
      .rgmii_mac_tx_rdy  (tx_rdy),
      .rgmii_mac_tx_data (txd),
      .rgmii_mac_tx_dv   (dv),
      .rgmii_mac_tx_er   (er),
      .mii_select        (mii_sel),
      .frame_done        (fdone),
      .underrun          (urun)
   );

   eth_tx_mac_gen2 #(
      .PREAMBLE_EN (1'b0),
      .PAD_EN      (1'b0)
   ) dut2 (
      .clk               (clk),
      .reset             (reset),
      .s_tx_axis_tdata   (b_tdata),
      .s_tx_axis_tvalid  (b_tvalid),
      .s_tx_axis_tlast   (b_tlast),
      .s_tx_axis_tuser   (b_tuser),
      .s_tx_axis_trdy    (b_trdy),
      .rgmii_mac_tx_rdy  (b_rdy),
      .rgmii_mac_tx_data (b_txd),
      .rgmii_mac_tx_dv   (b_dv),
      .rgmii_mac_tx_er   (b_er),
      .mii_select        (b_mii),
      .frame_done        (b_fdone),
      .underrun          (b_urun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Expected dv-cycle stream for dut: {er, data} per cycle.
   logic [8:0] exp_q[$];
   bit         chk_en = 1'b1;
   logic [8:0] e;
   int         byte_no = 0;

   int  cyc_n = 0, run_len = 0, trdy_cnt = 0, trdy_consec = 0;
   int  fd_cnt = 0, ur_cnt = 0, fd_cyc = 0, rise_cyc = 0;
   int  fd_pos = -1, ifg_gap = -1;
   bit  prev_dv = 1'b0, prev_trdy = 1'b0, fd_seen = 1'b0;
   int  runs[$];

   logic [7:0] b_q[$];
   int         b_fd = 0, b_er_cnt = 0, b_ur = 0;

   always @(negedge clk) begin
      cyc_n++;
      if (dv === 1'b1 && !prev_dv) begin
         rise_cyc = cyc_n;
         if (fd_seen) ifg_gap = cyc_n - fd_cyc - 1;
      end
      if (dv === 1'b1) run_len++;
      else if (prev_dv) begin
         runs.push_back(run_len);
         run_len = 0;
      end
      prev_dv = (dv === 1'b1);
      if (trdy === 1'b1) begin
         trdy_cnt++;
         if (prev_trdy) trdy_consec++;
      end
      prev_trdy = (trdy === 1'b1);
      if (fdone === 1'b1) begin
         fd_cnt++;
         fd_cyc  = cyc_n;
         fd_seen = 1'b1;
         fd_pos  = cyc_n - rise_cyc + 1;
      end
      if (urun === 1'b1) ur_cnt++;
      if (chk_en && reset === 1'b0 && dv === 1'b1) begin
         checks++;
         byte_no++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL stream #%0d: got data=%h er=%b, required no dv",
                     byte_no, txd, er);
         end else begin
            e = exp_q.pop_front();
            if ({er, txd} !== e) begin
               failures++;
               $display("FAIL stream #%0d: got data=%h er=%b, required data=%h er=%b",
                        byte_no, txd, er, e[7:0], e[8]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (b_dv === 1'b1) b_q.push_back(b_txd);
         if (b_fdone === 1'b1) b_fd++;
         if (b_er === 1'b1) b_er_cnt++;
         if (b_urun === 1'b1) b_ur++;
      end
   end

   task automatic check(input string name,
                        input logic [31:0] got,
                        input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h, required %0h", name, got, want);
      end
   endtask

   task automatic clr_stats();
      runs.delete();
      trdy_cnt    = 0;
      trdy_consec = 0;
      fd_cnt      = 0;
      ur_cnt      = 0;
      fd_seen     = 1'b0;
      fd_pos      = -1;
      ifg_gap     = -1;
   endtask

   function automatic int run_at(input int k);
      if (runs.size() > k) return runs[k];
      return -1;
   endfunction

   function automatic logic [31:0] crc_ref(input logic [31:0] c,
                                           input logic [7:0]  d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int k = 0; k < 8; k++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   // Payload byte i is (base+i) mod 256; cut>=0 means underrun after cut bytes.
   task automatic model_frame(input int n, input int base, input int bad,
                              input int cut, input bit mii);
      logic [8:0]  ent[$];
      logic [31:0] c;
      logic [31:0] f;
      int          len;
      for (int k = 0; k < 7; k++) ent.push_back({1'b0, 8'h55});
      ent.push_back({1'b0, 8'hD5});
      c   = 32'hFFFF_FFFF;
      len = (cut >= 0) ? cut : n;
      for (int i = 0; i < len; i++) begin
         ent.push_back({(i == bad), 8'(base + i)});
         c = crc_ref(c, 8'(base + i));
      end
      if (cut >= 0) begin
         ent.push_back({1'b1, 8'h00});
      end else begin
         for (int i = n; i < 60; i++) begin
            ent.push_back({1'b0, 8'h00});
            c = crc_ref(c, 8'h00);
         end
         f = ~c;
         for (int k = 0; k < 4; k++)
            ent.push_back({1'b0, 8'(f >> (8 * k))});
      end
      foreach (ent[k]) begin
         exp_q.push_back(ent[k]);
         if (mii) exp_q.push_back(ent[k]);
      end
   endtask

   task automatic send(input int n, input int base, input int bad,
                       input int cut, input int cut_len, input int rst_at,
                       output int acc_cnt);
      int i, cyc, idle;
      bit acc;
      i = 0; cyc = 0; idle = 0;
      while (i < n && cyc < 4000) begin
         if (rst_at >= 0 && i == rst_at) begin
            check("rst_pre_dv", dv, 1);
            tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
            reset  = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            check("rst_dv", dv, 0);
            check("rst_data", txd, 0);
            check("rst_er", er, 0);
            check("rst_trdy", trdy, 0);
            check("rst_fdone", fdone, 0);
            check("rst_urun", urun, 0);
            break;
         end
         if (cut >= 0 && i == cut && idle < cut_len) begin
            tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
            idle++;
         end else begin
            tvalid = 1'b1;
            tdata  = 8'(base + i);
            tlast  = (i == n - 1);
            tuser  = (i == bad);
         end
         @(negedge clk);
         acc = (trdy === 1'b1) && tvalid;
         @(posedge clk); #1;
         cyc++;
         if (acc) i++;
      end
      tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
      if (cyc >= 4000) begin
         failures++;
         $display("FAIL send_timeout: accepted %0d, required %0d", i, n);
      end
      acc_cnt = i;
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 3000) begin
         @(posedge clk);
         k++;
      end
      repeat (20) @(posedge clk);
      #1;
      check(name, exp_q.size(), 0);
   endtask

   logic [7:0] exp2 [13];
   int         acc;
   logic [31:0] c9;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      exp2 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
               8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
      reset = 1'b1;
      tdata = '0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
      tx_rdy = 1'b1; mii_sel = 1'b0;
      b_tdata = '0; b_tvalid = 1'b0; b_tlast = 1'b0; b_tuser = 1'b0;
      b_rdy = 1'b1; b_mii = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_data", txd, 0);
      check("reset_dv", dv, 0);
      check("reset_er", er, 0);
      check("reset_trdy", trdy, 0);
      check("reset_fdone", fdone, 0);
      check("reset_urun", urun, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Model pin: standard CRC-32 check value.
      c9 = 32'hFFFF_FFFF;
      for (int i = 0; i < 9; i++) c9 = crc_ref(c9, 8'(8'h31 + i));
      check("model_crc_check", ~c9, 32'hCBF4_3926);

      // No preamble, no pad: "123456789" then FCS.
      begin
         int i, cyc;
         bit a;
         i = 0; cyc = 0;
         while (i < 9 && cyc < 200) begin
            b_tvalid = 1'b1;
            b_tdata  = 8'(8'h31 + i);
            b_tlast  = (i == 8);
            @(negedge clk);
            a = (b_trdy === 1'b1);
            @(posedge clk); #1;
            cyc++;
            if (a) i++;
         end
         b_tvalid = 1'b0; b_tlast = 1'b0;
         check("t2_accepted", i, 9);
         repeat (30) @(posedge clk);
         #1;
         check("t2_len", b_q.size(), 13);
         for (int k = 0; k < 13; k++)
            if (k < b_q.size()) check("t2_byte", b_q[k], exp2[k]);
         check("t2_fdone", b_fd, 1);
         check("t2_er", b_er_cnt, 0);
         check("t2_urun", b_ur, 0);
      end

      // Gigabit, two back-to-back 64-byte frames.
      clr_stats();
      model_frame(64, 0, -1, -1, 1'b0);
      model_frame(64, 0, -1, -1, 1'b0);
      send(64, 0, -1, -1, 0, -1, acc);
      check("t1_trdy_cnt", trdy_cnt, 64);
      send(64, 0, -1, -1, 0, -1, acc);
      wait_drain("t1_drained");
      check("t1_run0", run_at(0), 76);
      check("t1_run1", run_at(1), 76);
      check("t1_ifg", ifg_gap, 12);
      check("t1_fd_pos", fd_pos, 76);
      check("t1_fd_cnt", fd_cnt, 2);

      // Short frame padded to 60 bytes.
      clr_stats();
      model_frame(10, 8'h80, -1, -1, 1'b0);
      send(10, 8'h80, -1, -1, 0, -1, acc);
      wait_drain("t3_drained");
      check("t3_run", run_at(0), 72);
      check("t3_fd_cnt", fd_cnt, 1);

      // MII pacing.
      mii_sel = 1'b1;
      clr_stats();
      model_frame(64, 8'h40, -1, -1, 1'b1);
      model_frame(8, 8'hC0, -1, -1, 1'b1);
      send(64, 8'h40, -1, -1, 0, -1, acc);
      check("t4_trdy_cnt", trdy_cnt, 64);
      check("t4_trdy_consec", trdy_consec, 0);
      send(8, 8'hC0, -1, -1, 0, -1, acc);
      wait_drain("t4_drained");
      mii_sel = 1'b0;
      check("t4_run0", run_at(0), 152);
      check("t4_run1", run_at(1), 144);
      check("t4_ifg", ifg_gap, 24);
      check("t4_fd_cnt", fd_cnt, 2);

      // Underrun after 20 bytes, 3 idle cycles, then drain to byte 40.
      clr_stats();
      model_frame(40, 8'h10, -1, 20, 1'b0);
      send(40, 8'h10, -1, 20, 3, -1, acc);
      check("t5_consumed", acc, 40);
      wait_drain("t5_drained");
      check("t5_urun", ur_cnt, 1);
      check("t5_fd_cnt", fd_cnt, 0);
      check("t5_run", run_at(0), 29);

      // tuser on byte index 5.
      clr_stats();
      model_frame(30, 8'h60, 5, -1, 1'b0);
      send(30, 8'h60, 5, -1, 0, -1, acc);
      wait_drain("t6_drained");
      check("t6_fd_cnt", fd_cnt, 1);
      check("t6_run", run_at(0), 72);

      // Reset at byte 30 of a frame, then a clean frame.
      chk_en = 1'b0;
      send(64, 8'h20, -1, -1, 0, 30, acc);
      check("t6_rst_at", acc, 30);
      repeat (3) @(posedge clk);
      #1;
      exp_q.delete();
      chk_en = 1'b1;
      clr_stats();
      model_frame(16, 8'hE0, -1, -1, 1'b0);
      send(16, 8'hE0, -1, -1, 0, -1, acc);
      wait_drain("t6b_drained");
      check("t6b_fd_cnt", fd_cnt, 1);
      check("t6b_run", run_at(0), 72);
      check("t6b_urun", ur_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/eth_tx_mac_gen2.md
Name: eth_tx_mac_gen2

Overview:
Parametrised second-generation Ethernet transmit MAC. Accepts frame payload bytes from the TX FIFO over an 8-bit AXI-Stream slave and drives the RGMII/MII adapter byte interface. Adds four things:
- configurable preamble/SFD insertion
- minimum-frame zero padding
- CRC-32 FCS append
- inter-frame gap (IFG) enforcement

It also supports gigabit (byte per cycle) and MII (byte per two cycles) modes, and handles underrun and tuser errors.

Parameters:
PREAMBLE_EN, 1, 1 = emit 7x 0x55 + 0xD5 before payload; 0 = payload starts immediately
PAD_EN, 1, 1 = zero-pad payload up to MIN_FRAME_BYTES
MIN_FRAME_BYTES, 60, minimum payload+pad length in bytes, excluding FCS (range 1..65535)
CRC_EN, 1, 1 = append 4-byte FCS
IFG_BYTES, 12, idle byte-times after each frame (range 1..255)

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
s_tx_axis_tdata  in  8  payload byte from FIFO
s_tx_axis_tvalid  in  1  FIFO has data
s_tx_axis_tlast  in  1  final payload byte
s_tx_axis_tuser  in  1  byte marked bad; forces tx_er
s_tx_axis_trdy  out  1  MAC accepts byte this cycle
rgmii_mac_tx_rdy  in  1  adapter ready; low stalls all byte advances
rgmii_mac_tx_data  out  8  byte to adapter
rgmii_mac_tx_dv  out  1  byte valid
rgmii_mac_tx_er  out  1  byte error
mii_select  in  1  1 = MII (10/100), 0 = gigabit; sampled only in IDLE
frame_done  out  1  one-cycle pulse when the last FCS (or last data) byte is issued
underrun  out  1  one-cycle pulse on payload underrun

Behaviour:
- Clock and reset: single clock. reset is synchronous and active-high.
- Reset values: state IDLE; all byte/phase/IFG counters 0; CRC = 0xFFFFFFFF. Outputs tx_data = 0x00, tx_dv = 0, tx_er = 0, trdy = 0, frame_done = 0, underrun = 0. Reset mid-frame aborts immediately; dv drops the cycle after reset is sampled. No FCS is emitted.
- Advance strobe:
  - adv = rgmii_mac_tx_rdy && (mode_mii ? phase : 1).
  - phase toggles every cycle when mode_mii; it is cleared in IDLE.
  - mode_mii is latched from mii_select on the IDLE -> start transition.
  - Outputs change only on adv cycles and otherwise hold. In MII mode each byte is therefore held for at least 2 cycles.
- Handshake:
  - trdy = adv && state == PAYLOAD, combinational. In DRAIN, trdy = 1.
  - A byte is accepted when tvalid && trdy. An accepted byte appears on tx_data on the next clock edge (latency 1).
- FSM states:
  - IDLE: if tvalid, go to PREAMBLE on the next adv (or PAYLOAD if !PREAMBLE_EN).
  - PREAMBLE: emit 7 bytes of 0x55 then 0xD5, dv = 1, then go to PAYLOAD.
  - PAYLOAD:
    - Each adv with tvalid emits tdata with dv = 1 and er = tuser, and updates the CRC and the byte count (16-bit, saturating).
    - On tlast: go to PAD if PAD_EN && count+1 < MIN_FRAME_BYTES; else FCS if CRC_EN; else IFG.
    - On an adv with tvalid = 0 (underrun): emit one byte 0x00 with dv = 1 and er = 1, pulse underrun, then go to DRAIN.
  - PAD: emit 0x00, dv = 1, CRC updated, until count == MIN_FRAME_BYTES. Then go to FCS (or IFG if !CRC_EN).
  - FCS:
    - Emit ~crc in 4 bytes, bits[7:0] first.
    - CRC-32 is the reflected form: poly 0xEDB88320, init 0xFFFFFFFF, computed over payload + pad only.
    - frame_done pulses with the last FCS byte.
  - DRAIN: dv = 0; discard FIFO bytes until tlast is accepted, then go to IFG. No frame_done.
  - IFG: dv = 0, tx_data = 0x00 for IFG_BYTES advs. Then reinitialise CRC and count and go to IDLE. trdy = 0 throughout, so back-to-back frames honour the full IFG.
- tuser: per-byte, no state change; the frame still completes with its FCS.
- Stall: rgmii_mac_tx_rdy = 0 freezes all state, counters and outputs. trdy = 0 while stalled.

Test Plan:
1. Gigabit, 64-byte payload 0x00..0x3F, tvalid held high, tx_rdy = 1 → 8 preamble cycles (0x55 x7, 0xD5), 64 payload cycles, 4 FCS cycles; dv high for exactly 76 consecutive cycles; trdy high for exactly 64 cycles; frame_done on cycle 76; then 12 cycles dv = 0 before the next preamble.
2. PAD_EN = 0, PREAMBLE_EN = 0, payload ASCII "123456789" → tx_data sequence 31..39, then FCS 0x26 0x39 0xF4 0xCB.
3. Default parameters, 10-byte payload → 10 data bytes, 50 bytes of 0x00, 4 FCS bytes; dv count = 8 + 60 + 4 = 72; FCS matches a reference model over the 60-byte padded payload.
4. mii_select = 1, 64-byte frame → trdy pulses on alternate cycles only; each tx_data value is held 2 cycles; dv high for 152 cycles; IFG spans 24 cycles.
5. Deassert tvalid for 3 cycles after byte 20, then resume to tlast at byte 40 → exactly one byte with er = 1 and data 0x00; underrun pulses once; dv = 0 during drain; remaining 20 bytes consumed; no FCS; no frame_done; IFG follows.
6. Assert tuser on byte 5; separately assert reset at byte 30 of a second frame → first frame has er = 1 only on byte 5 and completes with FCS. Second frame: dv = 0 the cycle after reset and all outputs at reset values; a new frame then starts cleanly with a fresh preamble.
